// File: rtl/oc8051_su_gate_pkg.sv
// Shared encodings for the supervisor gate controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package oc8051_su_gate_pkg;

  // FSM state encoding
  typedef enum logic [2:0] {
    ST_USER  = 3'd0,
    ST_ENTER = 3'd1,
    ST_SU    = 3'd2,
    ST_LEAVE = 3'd3,
    ST_FAULT = 3'd4
  } su_state_t;

  // Fault cause codes reported on fault_code
  localparam logic [1:0] FC_PROTO   = 2'b00;  // call and ret in the same cycle
  localparam logic [1:0] FC_BADGATE = 2'b01;  // protected target that is not a gate
  localparam logic [1:0] FC_OVF     = 2'b10;  // supervisor nesting overflow
  localparam logic [1:0] FC_LVL     = 2'b11;  // privilege counter disagrees with FSM

  // Default gate table and protected-region base
  localparam logic [15:0] GATE0_DEF     = 16'hF000;
  localparam logic [15:0] GATE1_DEF     = 16'hF010;
  localparam logic [15:0] GATE2_DEF     = 16'hF020;
  localparam logic [15:0] GATE3_DEF     = 16'hF030;
  localparam logic [15:0] PROT_BASE_DEF = 16'hF000;

  localparam logic [4:0] DEPTH_MAX = 5'd31;

endpackage

// File: rtl/oc8051_su_gate_match.sv
// Gate-hit and protected-range decode on a call target address.
// Latency: combinational, zero cycles.
// Backpressure: none; pure decode.
module oc8051_su_gate_match
  import oc8051_su_gate_pkg::*;
#(
  parameter logic [15:0] GATE0     = GATE0_DEF,
  parameter logic [15:0] GATE1     = GATE1_DEF,
  parameter logic [15:0] GATE2     = GATE2_DEF,
  parameter logic [15:0] GATE3     = GATE3_DEF,
  parameter logic [15:0] PROT_BASE = PROT_BASE_DEF
) (
  input  logic [15:0] i_addr,
  output logic        o_gate_hit,
  output logic        o_prot_hit
);

  // A gate is a legal entry even if it sits inside the protected region
  assign o_gate_hit = (i_addr == GATE0) || (i_addr == GATE1) ||
                      (i_addr == GATE2) || (i_addr == GATE3);
  assign o_prot_hit = (i_addr >= PROT_BASE);

endmodule

// File: rtl/oc8051_su_gate_ctrl.sv
// Supervisor gate FSM: admits calls only through gates, tracks nesting, flags faults.
// Latency: gated call at edge N -> enter pulse in N+1, SU in N+2; all outputs registered.
// Backpressure: stall held for the ENTER/LEAVE cycle and for the whole FAULT state.
module oc8051_su_gate_ctrl
  import oc8051_su_gate_pkg::*;
#(
  parameter logic [15:0] GATE0     = GATE0_DEF,
  parameter logic [15:0] GATE1     = GATE1_DEF,
  parameter logic [15:0] GATE2     = GATE2_DEF,
  parameter logic [15:0] GATE3     = GATE3_DEF,
  parameter logic [15:0] PROT_BASE = PROT_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        call_req,
  input  logic [15:0] call_addr,
  input  logic        ret_req,
  input  logic        drop_req,
  input  logic        priv_lvl,
  input  logic        fault_clr,
  output logic        enter_su_mode,
  output logic        leave_su_mode,
  output logic        stall,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [4:0]  nest_depth
);

  su_state_t  r_state;
  logic       r_enter;
  logic       r_leave;
  logic       r_stall;
  logic       r_fault;
  logic [1:0] r_code;
  logic [4:0] r_depth;

  logic       w_gate_hit;
  logic       w_prot_hit;

  oc8051_su_gate_match #(
    .GATE0     (GATE0),
    .GATE1     (GATE1),
    .GATE2     (GATE2),
    .GATE3     (GATE3),
    .PROT_BASE (PROT_BASE)
  ) u_match (
    .i_addr     (call_addr),
    .o_gate_hit (w_gate_hit),
    .o_prot_hit (w_prot_hit)
  );

  // State, depth and all outputs advance together; reset boots into supervisor
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_SU;
      r_enter <= 1'b0;
      r_leave <= 1'b0;
      r_stall <= 1'b0;
      r_fault <= 1'b0;
      r_code  <= FC_PROTO;
      r_depth <= 5'd0;
    end else begin
      // Pulses are single-cycle unless a branch below re-arms them
      r_enter <= 1'b0;
      r_leave <= 1'b0;
      case (r_state)
        ST_USER: begin
          if (call_req && ret_req) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
            r_stall <= 1'b1;
            r_code  <= FC_PROTO;
          end else if (call_req && w_gate_hit) begin
            r_state <= ST_ENTER;
            r_enter <= 1'b1;
            r_stall <= 1'b1;
          end else if (call_req && w_prot_hit) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
            r_stall <= 1'b1;
            r_code  <= FC_BADGATE;
          end
        end
        ST_ENTER: begin
          r_state <= ST_SU;
          r_stall <= 1'b0;
          r_depth <= 5'd0;
        end
        ST_SU: begin
          // Level mismatch outranks every core event; drop outranks call/ret
          if (!priv_lvl) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
            r_stall <= 1'b1;
            r_code  <= FC_LVL;
          end else if (drop_req) begin
            r_state <= ST_LEAVE;
            r_leave <= 1'b1;
            r_stall <= 1'b1;
            r_depth <= 5'd0;
          end else if (call_req && ret_req) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
            r_stall <= 1'b1;
            r_code  <= FC_PROTO;
          end else if (call_req) begin
            if (r_depth == DEPTH_MAX) begin
              r_state <= ST_FAULT;
              r_fault <= 1'b1;
              r_stall <= 1'b1;
              r_code  <= FC_OVF;
            end else begin
              r_depth <= r_depth + 5'd1;
            end
          end else if (ret_req) begin
            if (r_depth == 5'd0) begin
              r_state <= ST_LEAVE;
              r_leave <= 1'b1;
              r_stall <= 1'b1;
            end else begin
              r_depth <= r_depth - 5'd1;
            end
          end
        end
        ST_LEAVE: begin
          r_state <= ST_USER;
          r_stall <= 1'b0;
        end
        ST_FAULT: begin
          // Code and depth stay frozen for post-mortem until software clears
          if (fault_clr) begin
            r_state <= ST_USER;
            r_fault <= 1'b0;
            r_stall <= 1'b0;
            r_depth <= 5'd0;
          end
        end
        default: begin
          r_state <= ST_FAULT;
          r_fault <= 1'b1;
          r_stall <= 1'b1;
          r_code  <= FC_PROTO;
        end
      endcase
    end
  end

  assign enter_su_mode = r_enter;
  assign leave_su_mode = r_leave;
  assign stall         = r_stall;
  assign fault         = r_fault;
  assign fault_code    = r_code;
  assign nest_depth    = r_depth;

endmodule

// File: tb/tb_oc8051_su_gate_ctrl.sv
// Directed bench for the supervisor gate controller.
// Latency: inputs driven #1 after posedge, outputs checked #1 after the next posedge.
// Backpressure: n/a.
module tb_oc8051_su_gate_ctrl;

  logic        clk;
  logic        rst;
  logic        call_req;
  logic [15:0] call_addr;
  logic        ret_req;
  logic        drop_req;
  logic        priv_lvl;
  logic        fault_clr;
  logic        enter_su_mode;
  logic        leave_su_mode;
  logic        stall;
  logic        fault;
  logic [1:0]  fault_code;
  logic [4:0]  nest_depth;

  int n_checks = 0;
  int n_fail   = 0;

  oc8051_su_gate_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .call_req      (call_req),
    .call_addr     (call_addr),
    .ret_req       (ret_req),
    .drop_req      (drop_req),
    .priv_lvl      (priv_lvl),
    .fault_clr     (fault_clr),
    .enter_su_mode (enter_su_mode),
    .leave_su_mode (leave_su_mode),
    .stall         (stall),
    .fault         (fault),
    .fault_code    (fault_code),
    .nest_depth    (nest_depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; pulses must never overlap
  task automatic tick();
    @(posedge clk);
    #1;
    n_checks++;
    if ((enter_su_mode && leave_su_mode) !== 1'b0) begin
      $display("FAIL pulse_overlap: enter=%0b leave=%0b required not both 1", enter_su_mode, leave_su_mode);
      n_fail++;
    end
  endtask

  task automatic idle_inputs();
    call_req  = 1'b0;
    call_addr = 16'h0000;
    ret_req   = 1'b0;
    drop_req  = 1'b0;
    fault_clr = 1'b0;
  endtask

  // Drive a gated call from USER and step through ENTER into SU
  task automatic enter_from_user(input logic [15:0] addr);
    call_req = 1'b1; call_addr = addr;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    priv_lvl = 1'b1;
    rst = 1'b1;
    #3;
    n_checks++; if (stall !== 1'b0)         begin $display("FAIL reset_stall: got %0b required 0", stall); n_fail++; end
    n_checks++; if (fault !== 1'b0)         begin $display("FAIL reset_fault: got %0b required 0", fault); n_fail++; end
    n_checks++; if (fault_code !== 2'b00)   begin $display("FAIL reset_code: got %0b required 00", fault_code); n_fail++; end
    n_checks++; if (nest_depth !== 5'd0)    begin $display("FAIL reset_depth: got %0d required 0", nest_depth); n_fail++; end
    n_checks++; if (enter_su_mode !== 1'b0) begin $display("FAIL reset_enter: got %0b required 0", enter_su_mode); n_fail++; end
    n_checks++; if (leave_su_mode !== 1'b0) begin $display("FAIL reset_leave: got %0b required 0", leave_su_mode); n_fail++; end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Reset lands in SU, so drop_req gives one LEAVE cycle then USER
  task automatic test_drop_after_reset();
    drop_req = 1'b1;
    tick();
    idle_inputs();
    n_checks++; if (leave_su_mode !== 1'b1) begin $display("FAIL drop_leave: got %0b required 1", leave_su_mode); n_fail++; end
    n_checks++; if (stall !== 1'b1)         begin $display("FAIL drop_stall: got %0b required 1", stall); n_fail++; end
    tick();
    n_checks++; if (leave_su_mode !== 1'b0) begin $display("FAIL drop_leave_end: got %0b required 0", leave_su_mode); n_fail++; end
    n_checks++; if (stall !== 1'b0)         begin $display("FAIL drop_stall_end: got %0b required 0", stall); n_fail++; end
    // USER ignores ret/drop and unprotected calls
    ret_req = 1'b1; tick(); idle_inputs();
    drop_req = 1'b1; tick(); idle_inputs();
    call_req = 1'b1; call_addr = 16'h1234; tick(); idle_inputs();
    n_checks++; if ({enter_su_mode, leave_su_mode, stall, fault} !== 4'b0000) begin
      $display("FAIL user_ignore: got %4b required 0000", {enter_su_mode, leave_su_mode, stall, fault}); n_fail++; end
  endtask

  task automatic test_enter();
    call_req = 1'b1; call_addr = 16'hF010;
    tick();
    idle_inputs();
    n_checks++; if (enter_su_mode !== 1'b1) begin $display("FAIL enter_pulse: got %0b required 1", enter_su_mode); n_fail++; end
    n_checks++; if (stall !== 1'b1)         begin $display("FAIL enter_stall: got %0b required 1", stall); n_fail++; end
    tick();
    n_checks++; if (enter_su_mode !== 1'b0) begin $display("FAIL enter_pulse_end: got %0b required 0", enter_su_mode); n_fail++; end
    n_checks++; if (stall !== 1'b0)         begin $display("FAIL enter_stall_end: got %0b required 0", stall); n_fail++; end
    n_checks++; if (nest_depth !== 5'd0)    begin $display("FAIL enter_depth: got %0d required 0", nest_depth); n_fail++; end
    tick();
    n_checks++; if (fault !== 1'b0)         begin $display("FAIL enter_no_fault: got %0b required 0", fault); n_fail++; end
  endtask

  // Continues in SU from test_enter
  task automatic test_nesting();
    for (int i = 1; i <= 3; i++) begin
      call_req = 1'b1; call_addr = 16'h0100; tick(); idle_inputs();
      n_checks++; if (nest_depth !== 5'(i)) begin $display("FAIL nest_call%0d: got %0d required %0d", i, nest_depth, i); n_fail++; end
    end
    for (int i = 2; i >= 0; i--) begin
      ret_req = 1'b1; tick(); idle_inputs();
      n_checks++; if (nest_depth !== 5'(i)) begin $display("FAIL nest_ret: got %0d required %0d", nest_depth, i); n_fail++; end
      n_checks++; if (leave_su_mode !== 1'b0) begin $display("FAIL nest_early_leave: got %0b required 0", leave_su_mode); n_fail++; end
    end
    ret_req = 1'b1; tick(); idle_inputs();
    n_checks++; if (leave_su_mode !== 1'b1) begin $display("FAIL nest_leave: got %0b required 1", leave_su_mode); n_fail++; end
    tick();
    n_checks++; if ({leave_su_mode, stall} !== 2'b00) begin $display("FAIL nest_user: got %2b required 00", {leave_su_mode, stall}); n_fail++; end
  endtask

  // In USER: non-gate protected target faults; fault holds until cleared
  task automatic test_bad_gate();
    call_req = 1'b1; call_addr = 16'hF004; tick(); idle_inputs();
    n_checks++; if (fault !== 1'b1)          begin $display("FAIL badgate_fault: got %0b required 1", fault); n_fail++; end
    n_checks++; if (fault_code !== 2'b01)    begin $display("FAIL badgate_code: got %0b required 01", fault_code); n_fail++; end
    ret_req = 1'b1; tick(); idle_inputs();
    drop_req = 1'b1; tick(); idle_inputs();
    n_checks++; if ({fault, stall, fault_code} !== 4'b1101) begin
      $display("FAIL badgate_hold: got %4b required 1101", {fault, stall, fault_code}); n_fail++; end
    fault_clr = 1'b1; tick(); idle_inputs();
    n_checks++; if ({fault, stall} !== 2'b00) begin $display("FAIL badgate_clr: got %2b required 00", {fault, stall}); n_fail++; end
    // Still USER: a gate call enters
    call_req = 1'b1; call_addr = 16'hF000; tick(); idle_inputs();
    n_checks++; if (enter_su_mode !== 1'b1) begin $display("FAIL clr_then_enter: got %0b required 1", enter_su_mode); n_fail++; end
    tick();
  endtask

  // In SU at depth 0 on entry
  task automatic test_overflow();
    fault_clr = 1'b1; tick(); idle_inputs();
    n_checks++; if (fault !== 1'b0) begin $display("FAIL clr_outside_fault: got %0b required 0", fault); n_fail++; end
    for (int i = 0; i < 31; i++) begin
      call_req = 1'b1; call_addr = 16'h0200; tick(); idle_inputs();
    end
    n_checks++; if ({fault, nest_depth} !== {1'b0, 5'd31}) begin
      $display("FAIL ovf_depth31: got fault=%0b depth=%0d required 0/31", fault, nest_depth); n_fail++; end
    call_req = 1'b1; call_addr = 16'h0200; tick(); idle_inputs();
    n_checks++; if ({fault, fault_code} !== 3'b110) begin
      $display("FAIL ovf_code: got fault=%0b code=%0b required 1/10", fault, fault_code); n_fail++; end
    ret_req = 1'b1; tick(); idle_inputs();
    n_checks++; if (nest_depth !== 5'd31) begin $display("FAIL ovf_frozen: got %0d required 31", nest_depth); n_fail++; end
    fault_clr = 1'b1; tick(); idle_inputs();
    n_checks++; if ({fault, nest_depth} !== {1'b0, 5'd0}) begin
      $display("FAIL ovf_clr: got fault=%0b depth=%0d required 0/0", fault, nest_depth); n_fail++; end
    // SU, depth 1, then call+ret together
    enter_from_user(16'hF020);
    call_req = 1'b1; call_addr = 16'h0300; tick(); idle_inputs();
    call_req = 1'b1; ret_req = 1'b1; call_addr = 16'h0300; tick(); idle_inputs();
    n_checks++; if ({fault, fault_code, nest_depth} !== {1'b1, 2'b00, 5'd1}) begin
      $display("FAIL proto_su: got fault=%0b code=%0b depth=%0d required 1/00/1", fault, fault_code, nest_depth); n_fail++; end
    fault_clr = 1'b1; tick(); idle_inputs();
    call_req = 1'b1; ret_req = 1'b1; call_addr = 16'hF030; tick(); idle_inputs();
    n_checks++; if ({fault, fault_code, enter_su_mode} !== 4'b1000) begin
      $display("FAIL proto_user: got %4b required 1000", {fault, fault_code, enter_su_mode}); n_fail++; end
    fault_clr = 1'b1; tick(); idle_inputs();
  endtask

  task automatic test_level_and_rst();
    enter_from_user(16'hF030);
    call_req = 1'b1; call_addr = 16'h0400; tick(); idle_inputs();
    // Level check outranks a simultaneous drop
    priv_lvl = 1'b0; drop_req = 1'b1; tick(); idle_inputs(); priv_lvl = 1'b1;
    n_checks++; if ({fault, fault_code, leave_su_mode} !== 4'b1110) begin
      $display("FAIL lvl_fault: got %4b required 1110", {fault, fault_code, leave_su_mode}); n_fail++; end
    fault_clr = 1'b1; tick(); idle_inputs();
    // Reset in the middle of ENTER kills the pulse immediately
    call_req = 1'b1; call_addr = 16'hF010; tick(); idle_inputs();
    n_checks++; if (enter_su_mode !== 1'b1) begin $display("FAIL rst_pre_enter: got %0b required 1", enter_su_mode); n_fail++; end
    #2; rst = 1'b1; #1;
    n_checks++; if ({enter_su_mode, stall} !== 2'b00) begin
      $display("FAIL rst_abort_enter: got %2b required 00", {enter_su_mode, stall}); n_fail++; end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    // SU at depth 0: a RET leaves
    ret_req = 1'b1; tick(); idle_inputs();
    n_checks++; if (leave_su_mode !== 1'b1) begin $display("FAIL rst_state_su: got %0b required 1", leave_su_mode); n_fail++; end
    // Drop in SU at nonzero depth clears depth
    tick();
    enter_from_user(16'hF000);
    call_req = 1'b1; call_addr = 16'h0500; tick(); idle_inputs();
    drop_req = 1'b1; call_req = 1'b1; tick(); idle_inputs();
    n_checks++; if ({leave_su_mode, nest_depth} !== {1'b1, 5'd0}) begin
      $display("FAIL drop_depth: got leave=%0b depth=%0d required 1/0", leave_su_mode, nest_depth); n_fail++; end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_drop_after_reset();
    test_enter();
    test_nesting();
    test_bad_gate();
    test_overflow();
    test_level_and_rst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
